// File: rtl/dmem_stream_reader.sv
// dmem_stream_reader
// Read-side master for data-memory port 1. On start it walks `len` consecutive words from a
// word-aligned byte base address and streams them out through a small FIFO with valid/ready and
// a last flag.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, base_addr, len   transfer request (sampled only when idle)
//   mem_addr, mem_rdata     memory port 1 (combinational read, same-cycle data)
//   out_data/valid/last     registered FIFO head
//   out_ready               consumer accept
//   busy, done              status: busy while a transfer is in flight, done is a 1-cycle pulse
module dmem_stream_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;

  logic [31:0]           data_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic push, pop;
  logic unused_base;

  // Byte offset bits of the base are dropped on purpose.
  assign unused_base = ^base_addr[1:0];

  assign out_valid = (count_q != '0);
  assign out_data  = data_mem_q[rd_ptr_q];
  // Gate with valid: the slot under rd_ptr may hold a stale last tag once the FIFO empties.
  assign out_last  = out_valid & last_mem_q[rd_ptr_q];
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a fetch when the head leaves in the same cycle.
  assign push      = (state_q == StFetch) && ((count_q < CntW'(FIFO_DEPTH)) || pop);

  assign mem_addr  = addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            addr_d      = {base_addr[31:2], 2'b00};
            remaining_d = len;
            state_d     = StFetch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFetch: begin
        if (push) begin
          addr_d      = addr_q + 32'd4;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && out_last) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) data_mem_q[i] <= '0;
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= mem_rdata;
        last_mem_q[wr_ptr_q] <= (remaining_q == LEN_W'(1));
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Bench for dmem_stream_reader: directed transfers plus random-backpressure ones, checked against
// a reference built from the transfer rules (word i of a transfer is RAM[base/4 + i]).
module tb_dmem_stream_reader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   base_addr;
  logic [LW-1:0] len;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic [31:0] ram [1024];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[11:2]];

  dmem_stream_reader #(
    .FIFO_DEPTH(DEPTH),
    .LEN_W     (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready 0 for `stall` cycles then 1; mode 2: random.
  // hold keeps start high into the following cycle. abort_at>0 returns right after that many pops.
  task automatic run_xfer(input logic [31:0] base, input int n, input int mode, input int stall,
                          input bit hold, input int abort_at);
    logic [31:0] exp_q[$];
    logic [31:0] a0;
    logic [9:0]  idx;
    int          k         = 0;
    int          last_pop  = -1;
    int          dones     = 0;
    bit          post_done = 1'b0;
    bit          finished  = 1'b0;
    bit          aborted   = 1'b0;

    a0 = {base[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      idx = a0[11:2] + 10'(i);
      exp_q.push_back(ram[idx]);
    end

    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    len       = LW'(n);
    out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    if (!hold) begin
      start     = 1'b0;
      // An in-flight transfer must not see these.
      base_addr = $urandom;
      len       = LW'($urandom_range(1, 50));
    end

    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (post_done) begin
        chk("done_width", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        finished = 1'b1;
        break;
      end
      if (c == 0) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("first_valid_latency", 32'(out_valid), 32'd0);
        if (n > 0) chk("first_addr", mem_addr, a0);
      end
      if (mode == 1 && c < stall && n > 0 && out_valid) chk("stall_hold", out_data, exp_q[0]);
      if (mode == 1 && c == stall - 1 && n > int'(DEPTH))
        chk("stall_addr", mem_addr, a0 + 32'(4 * DEPTH));
      if (mode != 2 && out_ready && k > 0 && k < n) chk("no_gap", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        if (k < n) begin
          if (mode == 0 && k == 0) chk("first_word_cycle", 32'(c), 32'd1);
          chk("data", out_data, exp_q[k]);
          chk("last", 32'(out_last), 32'(k == n - 1));
        end else begin
          chk("extra_word", 32'(out_valid), 32'd0);
        end
        k++;
        last_pop = c;
      end
      if (done) begin
        dones++;
        chk("done_timing", 32'(c), 32'(last_pop + 1));
        chk("done_count", 32'(k), 32'(n));
        chk("done_busy", 32'(busy), 32'd1);
        post_done = 1'b1;
      end
      if (abort_at > 0 && k == abort_at) begin
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c + 1 >= stall) :
                  1'($urandom_range(0, 1));
    end

    if (!aborted) begin
      chk("completed", 32'(finished), 32'd1);
      chk("done_pulses", 32'(dones), 32'd1);
      if (n > 0) chk("final_addr", mem_addr, a0 + 32'(4 * n));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    for (int i = 0; i < 4; i++) ram[10'h40 + i] = 32'hA000_00A0 + 32'(i);

    repeat (2) @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    run_xfer(32'h0000_0100, 4, 0, 0, 1'b0, 0);
    run_xfer(32'h0000_0000, 10, 1, 20, 1'b0, 0);
    run_xfer(32'h0000_0000, 6, 2, 0, 1'b0, 0);
    run_xfer(32'h0000_0000, 0, 0, 0, 1'b1, 0);
    run_xfer(32'hFFFF_FFF8, 3, 0, 0, 1'b0, 0);
    run_xfer(32'h0000_0103, 2, 0, 0, 1'b0, 0);

    // Asynchronous reset mid-transfer, between clock edges.
    run_xfer(32'h0000_0200, 8, 0, 0, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_last", 32'(out_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_hold_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    run_xfer(32'h0000_0300, 5, 2, 0, 1'b0, 0);

    repeat (6) run_xfer($urandom, $urandom_range(1, 12), 2, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
